// File: rtl/tqvp_pwm_pkg.sv
// tqvp_pwm_pkg: register map, CTRL bit positions, bus access-size codes and the
// byte-lane merge shared by the PWM peripheral and its channels.
package tqvp_pwm_pkg;
    localparam logic [5:0] ADDR_CTRL   = 6'h00;
    localparam logic [5:0] ADDR_PERIOD = 6'h04;
    localparam logic [5:0] ADDR_STATUS = 6'h08;
    localparam logic [5:0] ADDR_COUNT  = 6'h0C;
    localparam logic [5:0] ADDR_DUTY0  = 6'h10;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_CLR     = 1;
    localparam int CTRL_PRE_LSB = 8;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_NONE = 2'b11;
    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] din,
                                               input logic [1:0] sz);
        logic [31:0] m;
        m = sz == SZ_BYTE ? 32'h0000_00FF : sz == SZ_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        return (old & ~m) | (din & m);
    endfunction
endpackage

// File: rtl/tqvp_pwm_channel.sv
// tqvp_pwm_channel: duty register plus registered compare for one PWM output.
// With PWM_SHADOW_EN defined the duty is double-buffered and loads on wrap_load.
module tqvp_pwm_channel
    import tqvp_pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic             en,
    input  logic             wrap_load,
    input  logic             we,
    input  logic [1:0]       size,
    input  logic [31:0]      data_in,
    output logic [CNT_W-1:0] duty_rd,
    output logic             pwm
);
    logic [CNT_W-1:0] duty;
    logic [CNT_W-1:0] duty_wr;
    assign duty_wr = CNT_W'(lane_merge(32'(duty_rd), data_in, size));
`ifdef PWM_SHADOW_EN
    logic [CNT_W-1:0] duty_sh;
    assign duty_rd = duty_sh;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh <= '0;
            duty    <= '0;
        end else begin
            if (we) duty_sh <= duty_wr;
            if (wrap_load) duty <= duty_sh;
        end
    end
`else
    logic unused_load;
    assign unused_load = wrap_load;
    assign duty_rd = duty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) duty <= '0;
        else if (we) duty <= duty_wr;
    end
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm <= 1'b0;
        else pwm <= en && (cnt < duty);
    end
endmodule

// File: rtl/tqvp_pwm_multi.sv
// tqvp_pwm_multi: TinyQV peripheral with NUM_CH PWM channels on one prescaled counter.
// Define PWM_SHADOW_EN to double-buffer PERIOD/DUTY so updates land on the wrap.
module tqvp_pwm_multi
    import tqvp_pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int PRE_W  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready
);
    logic             en, wrap_flag, we, rd, ctrl_we, per_we, clr, w1c, tick, wrap, load;
    logic [PRE_W-1:0] prescale, pre_cnt;
    logic [CNT_W-1:0] cnt, period, period_rd, period_wr;
    logic [31:0]      ctrl_rd, rd_mux;
    logic [NUM_CH-1:0] pwm;
    logic [CNT_W-1:0] duty_rd [NUM_CH];

    assign we        = data_write_n != SZ_NONE;
    assign rd        = data_read_n != SZ_NONE;
    assign ctrl_we   = we && address == ADDR_CTRL;
    assign per_we    = we && address == ADDR_PERIOD;
    assign clr       = ctrl_we && data_in[CTRL_CLR];
    assign w1c       = we && address == ADDR_STATUS && data_in[0];
    // CLR suppresses the tick entirely, so a clear on a wrap cycle neither wraps nor sets WRAP
    assign tick      = en && !clr && pre_cnt == prescale;
    assign wrap      = tick && cnt == period;
    assign load      = !en || wrap;
    assign ctrl_rd   = (32'(prescale) << CTRL_PRE_LSB) | 32'(en);
    assign period_wr = CNT_W'(lane_merge(32'(period_rd), data_in, data_write_n));
    assign uo_out    = 8'({pwm, 1'b0});

`ifdef PWM_SHADOW_EN
    logic [CNT_W-1:0] period_sh;
    assign period_rd = period_sh;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_sh <= '0;
            period    <= '0;
        end else begin
            if (per_we) period_sh <= period_wr;
            if (load) period <= period_sh;
        end
    end
`else
    assign period_rd = period;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) period <= '0;
        else if (per_we) period <= period_wr;
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tqvp_pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .cnt       (cnt),
            .en        (en),
            .wrap_load (load),
            .we        (we && address == ADDR_DUTY0 + 6'(4 * i)),
            .size      (data_write_n),
            .data_in   (data_in),
            .duty_rd   (duty_rd[i]),
            .pwm       (pwm[i])
        );
    end

    always_comb begin
        rd_mux = 32'd0;
        if (address == ADDR_CTRL) rd_mux = ctrl_rd;
        if (address == ADDR_PERIOD) rd_mux = 32'(period_rd);
        if (address == ADDR_STATUS) rd_mux = {16'd0, ui_in, 7'd0, wrap_flag};
        if (address == ADDR_COUNT) rd_mux = 32'(cnt);
        for (int c = 0; c < NUM_CH; c++)
            if (address == ADDR_DUTY0 + 6'(4 * c)) rd_mux = 32'(duty_rd[c]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en         <= 1'b0;
            prescale   <= '0;
            pre_cnt    <= '0;
            cnt        <= '0;
            wrap_flag  <= 1'b0;
            data_out   <= '0;
            data_ready <= 1'b0;
        end else begin
            if (ctrl_we) begin
                en       <= data_in[CTRL_EN];
                prescale <= PRE_W'(lane_merge(ctrl_rd, data_in, data_write_n) >> CTRL_PRE_LSB);
            end
            if (clr) begin
                pre_cnt <= '0;
                cnt     <= '0;
            end else if (en) begin
                pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
                if (tick) cnt <= wrap ? '0 : cnt + CNT_W'(1);
            end
            wrap_flag <= wrap || (wrap_flag && !w1c);
            if (rd) data_out <= rd_mux;
            data_ready <= rd;
        end
    end
endmodule

// File: tb/tb_tqvp_pwm_multi.sv
// tb_tqvp_pwm_multi: directed spot checks plus randomized bus traffic, every cycle
// compared against a behavioural model of the peripheral kept in the bench.
module tb_tqvp_pwm_multi;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int PRE_W  = 8;
    localparam logic [31:0] CMASK = 32'h0000_FFFF;
    localparam logic [31:0] PMASK = 32'h0000_00FF;
`ifdef PWM_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk, rst_n;
    logic [7:0]  ui_in, uo_out;
    logic [5:0]  address;
    logic [31:0] data_in, data_out;
    logic [1:0]  data_write_n, data_read_n;
    logic        data_ready;

    tqvp_pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ui_in        (ui_in),
        .uo_out       (uo_out),
        .address      (address),
        .data_in      (data_in),
        .data_write_n (data_write_n),
        .data_read_n  (data_read_n),
        .data_out     (data_out),
        .data_ready   (data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors, checks;

    logic              m_en, m_wrap, m_ready;
    logic [31:0]       m_pres, m_pre, m_cnt, m_per, m_per_sh, m_dout;
    logic [31:0]       m_duty [NUM_CH];
    logic [31:0]       m_duty_sh [NUM_CH];
    logic [NUM_CH-1:0] m_pwm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] din,
                                          input logic [1:0] sz);
        if (sz == 2'b00) return {old[31:8], din[7:0]};
        if (sz == 2'b01) return {old[31:16], din[15:0]};
        return din;
    endfunction

    function automatic logic [31:0] read_value(input logic [31:0] a);
        if (a == 32'h00) return (m_pres << 8) | 32'(m_en);
        if (a == 32'h04) return m_per_sh;
        if (a == 32'h08) return {16'h0, ui_in, 7'h0, m_wrap};
        if (a == 32'h0C) return m_cnt;
        if (a >= 32'h10 && a < 32'(16 + 4 * NUM_CH) && a[1:0] == 2'b00) return m_duty_sh[(a - 32'h10) >> 2];
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_en = 1'b0; m_wrap = 1'b0; m_ready = 1'b0;
        m_pres = 0; m_pre = 0; m_cnt = 0; m_per = 0; m_per_sh = 0; m_dout = 0; m_pwm = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_duty[i] = 0;
            m_duty_sh[i] = 0;
        end
    endtask

    // One clock edge of the peripheral, everything derived from the pre-edge state.
    task automatic model_step();
        logic we, rd, clr, tick, wrap;
        logic [31:0] a, v;
        a  = 32'(address);
        we = data_write_n != 2'b11;
        rd = data_read_n != 2'b11;
        for (int i = 0; i < NUM_CH; i++) m_pwm[i] = m_en && (m_cnt < m_duty[i]);
        if (rd) m_dout = read_value(a);
        m_ready = rd;
        clr  = we && a == 32'h0 && data_in[1];
        tick = m_en && !clr && m_pre == m_pres;
        wrap = tick && m_cnt == m_per;
        if (SHADOW && (!m_en || wrap)) begin
            m_per = m_per_sh;
            for (int i = 0; i < NUM_CH; i++) m_duty[i] = m_duty_sh[i];
        end
        if (clr) begin
            m_pre = 0;
            m_cnt = 0;
        end else if (m_en) begin
            m_pre = tick ? 32'd0 : (m_pre + 32'd1) & PMASK;
            if (tick) m_cnt = wrap ? 32'd0 : (m_cnt + 32'd1) & CMASK;
        end
        if (wrap) m_wrap = 1'b1;
        else if (we && a == 32'h8 && data_in[0]) m_wrap = 1'b0;
        if (we && a == 32'h4) m_per_sh = lanes(m_per_sh, data_in, data_write_n) & CMASK;
        for (int i = 0; i < NUM_CH; i++)
            if (we && a == 32'(16 + 4 * i)) m_duty_sh[i] = lanes(m_duty_sh[i], data_in, data_write_n) & CMASK;
        if (we && a == 32'h0) begin
            v = lanes((m_pres << 8) | 32'(m_en), data_in, data_write_n);
            m_en = v[0];
            m_pres = (v >> 8) & PMASK;
        end
        if (!SHADOW) begin
            m_per = m_per_sh;
            for (int i = 0; i < NUM_CH; i++) m_duty[i] = m_duty_sh[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        chk("uo_out", 32'(uo_out), 32'({m_pwm, 1'b0}));
        chk("data_ready", 32'(data_ready), 32'(m_ready));
        chk("data_out", data_out, m_dout);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
        address = a; data_in = d; data_write_n = sz; data_read_n = 2'b11;
        step();
        data_write_n = 2'b11;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] v);
        address = a; data_read_n = 2'b10; data_write_n = 2'b11;
        step();
        chk("rd_strobe", 32'(data_ready), 32'd1);
        v = data_out;
        data_read_n = 2'b11;
    endtask

    logic [5:0] addrs [10] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10, 6'h14, 6'h18, 6'h1C, 6'h3C, 6'h2C};

    initial begin
        logic [31:0] v;
        int hi, sum;
        errors = 0; checks = 0;
        rst_n = 1'b0; ui_in = 8'h00; address = 6'h0; data_in = 32'h0;
        data_write_n = 2'b11; data_read_n = 2'b11;
        model_reset();
        repeat (2) step();
        #2 rst_n = 1'b1;
        rd(6'h0C, v); chk("reset_count", v, 32'h0);
        // PERIOD=9, DUTY0=3: three high cycles out of every ten
        ui_in = 8'h5A;
        wr(6'h04, 32'd9, 2'b10);
        wr(6'h10, 32'd3, 2'b10);
        wr(6'h00, 32'h1, 2'b10);
        hi = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            hi += int'(uo_out[1]);
        end
        chk("duty3_highs", 32'(hi), 32'd6);
        rd(6'h08, v); chk("status_wrap", v, 32'h5A01);
        wr(6'h00, 32'h0, 2'b10);
        wr(6'h08, 32'h1, 2'b10);
        rd(6'h08, v); chk("status_w1c", v, 32'h5A00);
        // byte lanes and width truncation
        wr(6'h04, 32'h1234, 2'b10);
        wr(6'h04, 32'hAB, 2'b00);
        rd(6'h04, v); chk("byte_lane", v, 32'h12AB);
        wr(6'h04, 32'hFFFF_FFFF, 2'b10);
        rd(6'h04, v); chk("word_trunc", v, 32'h0000_FFFF);
        step();
        chk("ready_drop", 32'(data_ready), 32'd0);
        chk("dout_hold", data_out, 32'h0000_FFFF);
        rd(6'h3C, v); chk("unmapped_rd", v, 32'h0);
        // PRESCALE=3, PERIOD=1: COUNT advances every 4 clocks
        wr(6'h04, 32'd1, 2'b10);
        wr(6'h00, 32'h0302, 2'b10);
        wr(6'h00, 32'h0301, 2'b10);
        sum = 0;
        for (int k = 0; k < 8; k++) begin
            rd(6'h0C, v);
            sum += int'(v);
        end
        chk("prescale_sum", 32'(sum), 32'd4);
        chk("duty_gt_period", 32'(uo_out), 32'h02);
        repeat (5) step();
        rd(6'h0C, v); chk("count_before_clr", v, 32'd1);
        wr(6'h00, 32'h0303, 2'b10);
        rd(6'h0C, v); chk("count_after_clr", v, 32'd0);
        // asynchronous reset in the middle of a count with a read strobe live
        address = 6'h0C; data_read_n = 2'b10;
        step();
        data_read_n = 2'b11;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_uo_out", 32'(uo_out), 32'h0);
        chk("rst_ready", 32'(data_ready), 32'h0);
        chk("rst_dout", data_out, 32'h0);
        repeat (2) step();
        #2 rst_n = 1'b1;
        rd(6'h0C, v); chk("rst_count", v, 32'h0);
        rd(6'h00, v); chk("rst_ctrl", v, 32'h0);
        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            ui_in = 8'($urandom);
            address = addrs[$urandom_range(0, 9)];
            data_write_n = $urandom_range(0, 99) < 25 ? 2'($urandom_range(0, 2)) : 2'b11;
            data_read_n = $urandom_range(0, 99) < 30 ? 2'($urandom_range(0, 2)) : 2'b11;
            if (address == 6'h00)
                data_in = {16'h0, 8'($urandom_range(0, 3)), 6'h0,
                           $urandom_range(0, 9) == 0, $urandom_range(0, 7) != 0};
            else if ($urandom_range(0, 39) == 0)
                data_in = $urandom;
            else
                data_in = 32'($urandom_range(0, 24));
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
